// File: rtl/sparc_control_unit.sv
// Hardwired fetch/decode/execute sequencer for a reduced SPARC V8 subset.
// Drives all datapath strobes and mux selects; a watchdog halts the machine on a missing MOC.
module sparc_control_unit #(
  parameter logic [5:0] PASSA_OP    = 6'h3D,
  parameter logic [5:0] PASSB_OP    = 6'h3E,
  parameter logic [5:0] ADD_OP      = 6'h00,
  parameter int         MOC_TIMEOUT = 16
) (
  input  logic        i_clk,
  input  logic        i_clr_n,
  input  logic [31:0] i_ir,
  input  logic        i_moc,
  input  logic        i_bcond,
  output logic        o_rf_load_enable,
  output logic        o_ir_ld,
  output logic        o_mar_ld,
  output logic        o_mdr_ld,
  output logic        o_pc_ld,
  output logic        o_npc_ld,
  output logic        o_npc_clr,
  output logic        o_fr_ld,
  output logic        o_mov,
  output logic        o_rw,
  output logic [1:0]  o_type,
  output logic [1:0]  o_ma,
  output logic [1:0]  o_mb,
  output logic [1:0]  o_mnp,
  output logic [1:0]  o_mp,
  output logic [1:0]  o_msc,
  output logic        o_mc,
  output logic        o_mm,
  output logic        o_mop,
  output logic        o_msa,
  output logic        o_mf,
  output logic [5:0]  o_opxx,
  output logic [3:0]  o_state,
  output logic        o_illegal,
  output logic        o_timeout
);

  localparam int WAIT_W = $clog2(MOC_TIMEOUT + 1);

  // ILL and HALT_TO share one halt state; the sticky flags tell them apart.
  typedef enum logic [3:0] {
    S_RST0 = 4'd0,  S_RST1 = 4'd1,  S_F0   = 4'd2,  S_F1   = 4'd3,
    S_DEC  = 4'd4,  S_ALU  = 4'd5,  S_LD0  = 4'd6,  S_LD1  = 4'd7,
    S_LD2  = 4'd8,  S_ST0  = 4'd9,  S_ST1  = 4'd10, S_ST2  = 4'd11,
    S_BR   = 4'd12, S_CALL = 4'd13, S_UPD  = 4'd14, S_HALT = 4'd15
  } state_t;

  state_t              r_state, w_state_next;
  logic [WAIT_W-1:0]   r_wait_cnt, w_wait_cnt_next, w_wait_inc;
  logic                r_illegal, r_timeout;
  logic                w_set_illegal, w_set_timeout;
  logic                w_in_wait, w_expired;
  logic                w_unused_ir;

  assign w_unused_ir = ^{i_ir[29:25], i_ir[18:14], i_ir[12:0]};

  assign w_in_wait  = (r_state == S_F1) || (r_state == S_LD1) || (r_state == S_ST2);
  assign w_wait_inc = r_wait_cnt + WAIT_W'(1);
  // A wait state lasts at most MOC_TIMEOUT cycles; MOC on the last of them still counts.
  assign w_expired  = (w_wait_inc == WAIT_W'(MOC_TIMEOUT));

  always_ff @(posedge i_clk) begin
    if (!i_clr_n) begin
      r_state    <= S_RST0;
      r_wait_cnt <= '0;
      r_illegal  <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_wait_cnt <= w_wait_cnt_next;
      r_illegal  <= r_illegal | w_set_illegal;
      r_timeout  <= r_timeout | w_set_timeout;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_wait_cnt_next = '0;
    w_set_illegal   = 1'b0;
    w_set_timeout   = 1'b0;
    case (r_state)
      S_RST0: w_state_next = S_RST1;
      S_RST1: w_state_next = S_F0;
      S_F0:   w_state_next = S_F1;
      S_F1:   w_state_next = S_DEC;
      S_DEC: begin
        case (i_ir[31:30])
          2'b01: w_state_next = S_CALL;
          2'b10: w_state_next = S_ALU;
          2'b00: begin
            if (i_ir[24:22] == 3'b010) begin
              w_state_next = S_BR;
            end else begin
              w_state_next  = S_HALT;
              w_set_illegal = 1'b1;
            end
          end
          default: begin
            if (i_ir[24:19] == 6'b000000) begin
              w_state_next = S_LD0;
            end else if (i_ir[24:19] == 6'b000100) begin
              w_state_next = S_ST0;
            end else begin
              w_state_next  = S_HALT;
              w_set_illegal = 1'b1;
            end
          end
        endcase
      end
      S_ALU:  w_state_next = S_UPD;
      S_LD0:  w_state_next = S_LD1;
      S_LD1:  w_state_next = S_LD2;
      S_LD2:  w_state_next = S_UPD;
      S_ST0:  w_state_next = S_ST1;
      S_ST1:  w_state_next = S_ST2;
      S_ST2:  w_state_next = S_UPD;
      S_BR:   w_state_next = S_F0;
      S_CALL: w_state_next = S_F0;
      S_UPD:  w_state_next = S_F0;
      S_HALT: w_state_next = S_HALT;
    endcase
    if (w_in_wait && !i_moc) begin
      if (w_expired) begin
        w_state_next  = S_HALT;
        w_set_timeout = 1'b1;
      end else begin
        w_state_next    = r_state;
        w_wait_cnt_next = w_wait_inc;
      end
    end
  end

  assign o_type    = 2'b10;
  assign o_state   = r_state;
  assign o_illegal = r_illegal;
  assign o_timeout = r_timeout;

  always_comb begin
    o_rf_load_enable = 1'b0;
    o_ir_ld          = 1'b0;
    o_mar_ld         = 1'b0;
    o_mdr_ld         = 1'b0;
    o_pc_ld          = 1'b0;
    o_npc_ld         = 1'b0;
    o_npc_clr        = 1'b0;
    o_fr_ld          = 1'b0;
    o_mov            = 1'b0;
    o_rw             = 1'b0;
    o_ma             = 2'd0;
    o_mb             = 2'd0;
    o_mnp            = 2'd0;
    o_mp             = 2'd0;
    o_msc            = 2'd0;
    o_mc             = 1'b0;
    o_mm             = 1'b0;
    o_mop            = 1'b0;
    o_msa            = 1'b0;
    o_mf             = 1'b0;
    o_opxx           = 6'd0;
    case (r_state)
      S_RST0: begin
        o_pc_ld   = 1'b1;
        o_npc_clr = 1'b1;
      end
      S_RST1: begin
        o_npc_ld = 1'b1;
        o_mnp    = 2'd3;
      end
      S_F0: begin
        o_mar_ld = 1'b1;
        o_mb     = 2'd2;
        o_mop    = 1'b1;
        o_opxx   = PASSB_OP;
      end
      S_F1: begin
        o_mov   = 1'b1;
        o_rw    = 1'b1;
        o_ir_ld = i_moc;
      end
      S_ALU: begin
        o_rf_load_enable = 1'b1;
        o_mb             = {1'b0, i_ir[13]};
        o_fr_ld          = i_ir[23];
      end
      S_LD0, S_ST0: begin
        o_mar_ld = 1'b1;
        o_mb     = {1'b0, i_ir[13]};
        o_mop    = 1'b1;
        o_opxx   = ADD_OP;
      end
      S_LD1: begin
        o_mov    = 1'b1;
        o_rw     = 1'b1;
        o_mdr_ld = i_moc;
      end
      S_LD2: begin
        o_rf_load_enable = 1'b1;
        o_mb             = 2'd3;
        o_mop            = 1'b1;
        o_opxx           = PASSB_OP;
      end
      S_ST1: begin
        o_mdr_ld = 1'b1;
        o_msa    = 1'b1;
        o_mop    = 1'b1;
        o_opxx   = PASSA_OP;
        o_mm     = 1'b1;
      end
      S_ST2: begin
        o_mov = 1'b1;
      end
      S_BR: begin
        o_pc_ld  = 1'b1;
        o_mp     = 2'd3;
        o_npc_ld = 1'b1;
        o_mnp    = i_bcond ? 2'd2 : 2'd3;
      end
      S_CALL: begin
        o_rf_load_enable = 1'b1;
        o_msc            = 2'd1;
        o_mb             = 2'd2;
        o_mop            = 1'b1;
        o_opxx           = PASSB_OP;
        o_pc_ld          = 1'b1;
        o_mp             = 2'd3;
        o_npc_ld         = 1'b1;
        o_mnp            = 2'd2;
      end
      S_UPD: begin
        o_pc_ld  = 1'b1;
        o_mp     = 2'd3;
        o_npc_ld = 1'b1;
        o_mnp    = 2'd3;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sparc_control_unit.sv
// Trace-based bench: a model expands each instruction into expected per-cycle
// state/control records, which are then replayed against the control unit.
module tb_sparc_control_unit;

  localparam logic [5:0] PASSA = 6'h3D;
  localparam logic [5:0] PASSB = 6'h3E;
  localparam logic [5:0] ADDOP = 6'h00;
  localparam int         TMO   = 16;

  localparam logic [3:0] ST_RST0 = 4'd0,  ST_RST1 = 4'd1,  ST_F0  = 4'd2,  ST_F1   = 4'd3;
  localparam logic [3:0] ST_DEC  = 4'd4,  ST_ALU  = 4'd5,  ST_LD0 = 4'd6,  ST_LD1  = 4'd7;
  localparam logic [3:0] ST_LD2  = 4'd8,  ST_ST0  = 4'd9,  ST_ST1 = 4'd10, ST_ST2  = 4'd11;
  localparam logic [3:0] ST_BR   = 4'd12, ST_CALL = 4'd13, ST_UPD = 4'd14, ST_HALT = 4'd15;

  localparam int K_ALU = 0, K_LD = 1, K_ST = 2, K_BR = 3, K_CALL = 4, K_ILL = 5;

  typedef struct packed {
    logic rf, ir_ld, mar, mdr, pc, npc, npc_clr, fr, mov, rw;
    logic [1:0] typ, ma, mb, mnp, mp, msc;
    logic mc, mm, mop, msa, mf;
    logic [5:0] op;
    logic ill, to;
  } ctrl_t;

  typedef struct packed {
    logic        clr;
    logic        moc;
    logic        bc;
    logic [31:0] ir;
    logic [3:0]  st;
    ctrl_t       c;
  } rec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        clr_n, moc, bcond;
  logic [31:0] ir;
  logic        rf, ir_ld, mar, mdr, pc, npc, npc_clr, fr, mov, rw;
  logic [1:0]  typ, ma, mb, mnp, mp, msc;
  logic        mc, mm, mop, msa, mf, ill, to;
  logic [5:0]  op;
  logic [3:0]  state;
  ctrl_t       obs;

  sparc_control_unit dut (
    .i_clk(clk), .i_clr_n(clr_n), .i_ir(ir), .i_moc(moc), .i_bcond(bcond),
    .o_rf_load_enable(rf), .o_ir_ld(ir_ld), .o_mar_ld(mar), .o_mdr_ld(mdr),
    .o_pc_ld(pc), .o_npc_ld(npc), .o_npc_clr(npc_clr), .o_fr_ld(fr),
    .o_mov(mov), .o_rw(rw), .o_type(typ), .o_ma(ma), .o_mb(mb), .o_mnp(mnp),
    .o_mp(mp), .o_msc(msc), .o_mc(mc), .o_mm(mm), .o_mop(mop), .o_msa(msa),
    .o_mf(mf), .o_opxx(op), .o_state(state), .o_illegal(ill), .o_timeout(to)
  );

  assign obs = {rf, ir_ld, mar, mdr, pc, npc, npc_clr, fr, mov, rw,
                typ, ma, mb, mnp, mp, msc, mc, mm, mop, msa, mf, op, ill, to};

  rec_t        q[$];
  logic [31:0] cur_ir;
  logic        cur_bc;
  int          n_checks = 0;
  int          n_errors = 0;
  int          step = 0;

  function automatic ctrl_t idle();
    ctrl_t c;
    c = '0;
    c.typ = 2'b10;
    return c;
  endfunction

  function automatic logic noise();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic void push(input logic [3:0] st, input ctrl_t c, input logic m);
    rec_t r;
    r.clr = 1'b1; r.moc = m; r.bc = cur_bc; r.ir = cur_ir; r.st = st; r.c = c;
    q.push_back(r);
  endfunction

  function automatic int classify(input logic [31:0] x);
    case (x[31:30])
      2'b01:   return K_CALL;
      2'b10:   return K_ALU;
      2'b00:   return (x[24:22] == 3'b010) ? K_BR : K_ILL;
      default: return (x[24:19] == 6'd0) ? K_LD : ((x[24:19] == 6'd4) ? K_ST : K_ILL);
    endcase
  endfunction

  function automatic logic [31:0] make_ir(input int kind);
    logic [31:0] r;
    r = $urandom();
    case (kind)
      K_ALU:  r[31:30] = 2'b10;
      K_LD:   begin r[31:30] = 2'b11; r[24:19] = 6'b000000; end
      K_ST:   begin r[31:30] = 2'b11; r[24:19] = 6'b000100; end
      K_BR:   begin r[31:30] = 2'b00; r[24:22] = 3'b010; end
      K_CALL: r[31:30] = 2'b01;
      default: begin
        r[31:30] = 2'b11;
        if (r[24:19] == 6'd0 || r[24:19] == 6'd4) r[24:19] = 6'b111111;
      end
    endcase
    return r;
  endfunction

  // Reset sequence as seen after the edge that samples Clr_n low.
  task automatic rst_seq();
    ctrl_t c;
    c = idle(); c.pc = 1'b1; c.npc_clr = 1'b1; push(ST_RST0, c, noise());
    c = idle(); c.npc = 1'b1; c.mnp = 2'd3; push(ST_RST1, c, noise());
  endtask

  task automatic assert_reset_on_last();
    q[q.size() - 1].clr = 1'b0;
    rst_seq();
  endtask

  task automatic fetch_stall(input int n);
    ctrl_t c;
    c = idle(); c.mar = 1'b1; c.mb = 2'd2; c.mop = 1'b1; c.op = PASSB;
    push(ST_F0, c, noise());
    c = idle(); c.mov = 1'b1; c.rw = 1'b1;
    for (int i = 0; i < n; i++) push(ST_F1, c, 1'b0);
  endtask

  task automatic mem_wait(input logic [3:0] st, input logic rdwr, input int waits);
    ctrl_t c;
    c = idle(); c.mov = 1'b1; c.rw = rdwr;
    for (int i = 0; i < waits; i++) push(st, c, 1'b0);
    if (st == ST_LD1) c.mdr = 1'b1;
    push(st, c, 1'b1);
  endtask

  task automatic upd();
    ctrl_t c;
    c = idle(); c.pc = 1'b1; c.mp = 2'd3; c.npc = 1'b1; c.mnp = 2'd3;
    push(ST_UPD, c, noise());
  endtask

  task automatic exec(input logic [31:0] x, input logic bc, input int w1, input int w2);
    ctrl_t c;
    cur_ir = x; cur_bc = bc;
    fetch_stall(w1);
    mem_wait(ST_F1, 1'b1, 0);
    q[q.size() - 1].c.ir_ld = 1'b1;
    q[q.size() - 1].c.mdr = 1'b0;
    push(ST_DEC, idle(), noise());
    case (classify(x))
      K_ALU: begin
        c = idle(); c.rf = 1'b1; c.mb = {1'b0, x[13]}; c.fr = x[23];
        push(ST_ALU, c, noise()); upd();
      end
      K_LD: begin
        c = idle(); c.mar = 1'b1; c.mb = {1'b0, x[13]}; c.mop = 1'b1; c.op = ADDOP;
        push(ST_LD0, c, noise());
        mem_wait(ST_LD1, 1'b1, w2);
        c = idle(); c.rf = 1'b1; c.mb = 2'd3; c.mop = 1'b1; c.op = PASSB;
        push(ST_LD2, c, noise()); upd();
      end
      K_ST: begin
        c = idle(); c.mar = 1'b1; c.mb = {1'b0, x[13]}; c.mop = 1'b1; c.op = ADDOP;
        push(ST_ST0, c, noise());
        c = idle(); c.mdr = 1'b1; c.msa = 1'b1; c.mop = 1'b1; c.op = PASSA; c.mm = 1'b1;
        push(ST_ST1, c, noise());
        mem_wait(ST_ST2, 1'b0, w2); upd();
      end
      K_BR: begin
        c = idle(); c.pc = 1'b1; c.mp = 2'd3; c.npc = 1'b1; c.mnp = bc ? 2'd2 : 2'd3;
        push(ST_BR, c, noise());
      end
      K_CALL: begin
        c = idle(); c.rf = 1'b1; c.msc = 2'd1; c.mb = 2'd2; c.mop = 1'b1; c.op = PASSB;
        c.pc = 1'b1; c.mp = 2'd3; c.npc = 1'b1; c.mnp = 2'd2;
        push(ST_CALL, c, noise());
      end
      default: begin
        c = idle(); c.ill = 1'b1;
        for (int i = 0; i < 3; i++) push(ST_HALT, c, noise());
      end
    endcase
  endtask

  task automatic run();
    rec_t r;
    while (q.size() > 0) begin
      r = q.pop_front();
      clr_n = r.clr; moc = r.moc; bcond = r.bc; ir = r.ir;
      @(negedge clk);
      n_checks++;
      assert (state === r.st) else begin
        n_errors++;
        $error("FAIL state step=%0d observed=%0d expected=%0d", step, state, r.st);
      end
      n_checks++;
      assert (obs === r.c) else begin
        n_errors++;
        $error("FAIL ctrl step=%0d state=%0d observed=%h expected=%h", step, r.st, obs, r.c);
      end
      @(posedge clk);
      #1;
      step++;
    end
  endtask

  initial begin
    ctrl_t c;
    int    kind;
    clr_n = 1'b0; moc = 1'b0; bcond = 1'b0; ir = '0;
    cur_ir = '0; cur_bc = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    // Reset release: RST0, RST1, then first fetch.
    rst_seq(); run();
    // ADD with immediate MOC.
    exec(32'h86004002, 1'b0, 0, 0); run();
    // LD with MOC three cycles late.
    exec(32'hC2006004, 1'b0, 0, 3); run();
    // Bicc taken and not taken.
    exec(32'h12800004, 1'b1, 0, 0); run();
    exec(32'h12800004, 1'b0, 1, 0); run();
    // UNIMP halts with Illegal until reset.
    exec(32'h00000000, 1'b0, 0, 0); assert_reset_on_last(); run();
    // MOC on the last permitted wait cycle is accepted.
    exec(32'h86004002, 1'b0, TMO - 1, 0); run();
    exec(32'hC2006004, 1'b0, 0, TMO - 1); run();
    // Reset in the middle of a fetch wait.
    cur_ir = 32'h86004002;
    fetch_stall(5); assert_reset_on_last(); run();
    // MOC never arrives: halt with Timeout until reset.
    fetch_stall(TMO);
    c = idle(); c.to = 1'b1;
    for (int i = 0; i < 3; i++) push(ST_HALT, c, noise());
    assert_reset_on_last(); run();
    // Randomised instruction mix with random memory latencies.
    for (int n = 0; n < 60; n++) begin
      kind = int'($urandom_range(0, 5));
      exec(make_ir(kind), noise(), int'($urandom_range(0, 4)), int'($urandom_range(0, 4)));
      if (kind == K_ILL) assert_reset_on_last();
      run();
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global time limit reached");
    $fatal(1, "time limit");
  end

endmodule
